mul_div_ctrl: RTL and testbench

Sequencing controller for the shared multiply/divide resource and the HI/LO register pair in the five-stage pipeline. It accepts E-stage mult/multu/div/divu/mthi/mtlo operations and models the fixed multi-cycle latency of the unit with a busy counter. It commits results to HI/LO at completion and raises a stall request whenever a D-stage HI/LO-class instruction would collide with an operation that is in flight.

---
 rtl/mul_div_ctrl_if.sv | 26 ++
 rtl/mul_div_ctrl.sv | 110 +++++++++++
 tb/tb_mul_div_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_ctrl_if.sv
// Bundle of the E/D-stage request signals and HI/LO results exchanged with mul_div_ctrl.
// The master drives operations and operands; the slave (controller) returns status and HI/LO.
interface mul_div_ctrl_if;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_sel;
    logic        d_md;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;
    logic [3:0]  dbg_cnt;

    modport master (
        output md_op, rs_val, rt_val, mf_sel, d_md,
        input  start, busy, stall_req, hi, lo, mf_data, dbg_cnt
    );

    modport slave (
        input  md_op, rs_val, rt_val, mf_sel, d_md,
        output start, busy, stall_req, hi, lo, mf_data, dbg_cnt
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// Multiply/divide sequencing controller: fixed-latency busy counter, shadow result
// registers committed to HI/LO at completion, and D-stage stall request generation.
module mul_div_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    mul_div_ctrl_if.slave       md
);
    // Handshake: md_op 1..4 is a request that is valid every cycle it is presented;
    // start is the acceptance (valid && !busy). Requests presented while busy are dropped,
    // so the pipeline must hold them in D using stall_req until busy falls.
    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi_q, hi_nxt, lo_q, lo_nxt;
    logic [31:0] pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
    logic        pend_we, pend_we_nxt;

    logic        is_mul, is_div, busy_w, start_w;
    logic [63:0] prod_s, prod_u;
    logic        div_ovf;
    logic [31:0] div_rt, q_s, r_s, q_u, r_u;

    assign is_mul  = (md.md_op == 3'd1) || (md.md_op == 3'd2);
    assign is_div  = (md.md_op == 3'd3) || (md.md_op == 3'd4);
    assign busy_w  = (cnt != 4'd0);
    assign start_w = (is_mul || is_div) && !busy_w;

    assign prod_s = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
                    $signed({{32{md.rt_val[31]}}, md.rt_val});
    assign prod_u = {32'd0, md.rs_val} * {32'd0, md.rt_val};

    // Zero divisor and the signed MIN/-1 overflow both divide by 1 so the datapath never
    // hits an undefined quotient; the zero case is suppressed later via pend_we.
    assign div_ovf = (md.md_op == 3'd3) && (md.rs_val == 32'h8000_0000) &&
                     (md.rt_val == 32'hFFFF_FFFF);
    assign div_rt  = ((md.rt_val == 32'd0) || div_ovf) ? 32'd1 : md.rt_val;
    assign q_s     = $signed(md.rs_val) / $signed(div_rt);
    assign r_s     = $signed(md.rs_val) % $signed(div_rt);
    assign q_u     = md.rs_val / div_rt;
    assign r_u     = md.rs_val % div_rt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_we <= pend_we_nxt;
        end
    end

    always_comb begin
        cnt_nxt     = cnt;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_we_nxt = pend_we;
        if (start_w) begin
            cnt_nxt     = is_mul ? MULT_N : DIV_N;
            pend_we_nxt = 1'b1;
            case (md.md_op)
                3'd1: {pend_hi_nxt, pend_lo_nxt} = prod_s;
                3'd2: {pend_hi_nxt, pend_lo_nxt} = prod_u;
                3'd3: begin
                    pend_hi_nxt = r_s;
                    pend_lo_nxt = q_s;
                    pend_we_nxt = (md.rt_val != 32'd0);
                end
                default: begin
                    pend_hi_nxt = r_u;
                    pend_lo_nxt = q_u;
                    pend_we_nxt = (md.rt_val != 32'd0);
                end
            endcase
        end else if (busy_w) begin
            cnt_nxt = cnt - 4'd1;
            if ((cnt == 4'd1) && pend_we) begin
                hi_nxt = pend_hi;
                lo_nxt = pend_lo;
            end
        end else if (md.md_op == 3'd5) begin
            hi_nxt = md.rs_val;
        end else if (md.md_op == 3'd6) begin
            lo_nxt = md.rs_val;
        end
    end

    always_comb begin
        md.start     = start_w;
        md.busy      = busy_w;
        md.stall_req = md.d_md && (start_w || busy_w);
        md.hi        = hi_q;
        md.lo        = lo_q;
        md.mf_data   = md.mf_sel ? hi_q : lo_q;
        md.dbg_cnt   = cnt;
    end
endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl: hand-computed HI/LO results, busy/stall windows,
// mthi/mtlo, divide-by-zero and reset in mid-operation.
module tb_mul_div_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  mul_div_ctrl_if md ();

  mul_div_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int proto = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  // Any HI/LO-class op offered while the unit is busy is an illegal pipeline sequence.
  always @(negedge clk) begin
    if (!reset && md.busy && (md.md_op inside {[3'd1:3'd6]})) proto++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div in cycle 0, walk the busy cycles, check the result in cycle n+1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d, input int n, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic we);
    logic [31:0] want_hi, want_lo;
    exp_q.push_back(we ? e_hi : m_hi);
    exp_q.push_back(we ? e_lo : m_lo);
    md.md_op = op;
    md.rs_val = a;
    md.rt_val = b;
    md.d_md = d;
    #2;
    check("start_c0", md.start, 32'd1);
    check("busy_c0", md.busy, 32'd0);
    check("stall_c0", md.stall_req, {31'd0, d});
    tick();
    md.md_op = 3'd0;
    for (int i = 1; i <= n; i++) begin
      #2;
      check("busy_run", md.busy, 32'd1);
      check("start_run", md.start, 32'd0);
      check("stall_run", md.stall_req, {31'd0, d});
      check("hi_hold", md.hi, m_hi);
      check("lo_hold", md.lo, m_lo);
      tick();
    end
    #2;
    want_hi = exp_q.pop_front();
    want_lo = exp_q.pop_front();
    check("busy_done", md.busy, 32'd0);
    check("stall_done", md.stall_req, 32'd0);
    check("hi_done", md.hi, want_hi);
    check("lo_done", md.lo, want_lo);
    m_hi = want_hi;
    m_lo = want_lo;
  endtask

  initial begin
    reset = 1'b1;
    md.md_op = 3'd0;
    md.rs_val = 32'd0;
    md.rt_val = 32'd0;
    md.mf_sel = 1'b0;
    md.d_md = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    tick();
    #2;
    check("rst_busy", md.busy, 32'd0);
    check("rst_start", md.start, 32'd0);
    check("rst_stall", md.stall_req, 32'd0);
    check("rst_hi", md.hi, 32'd0);
    check("rst_lo", md.lo, 32'd0);
    check("rst_mf", md.mf_data, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // mult -3 * 5 with d_md held high: stall window spans cycles 0..5
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
    md.mf_sel = 1'b1;
    #1;
    check("mf_hi", md.mf_data, 32'hFFFF_FFFF);
    md.mf_sel = 1'b0;
    #1;
    check("mf_lo", md.mf_data, 32'hFFFF_FFF1);
    md.d_md = 1'b0;
    tick();

    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    tick();

    // div -7 / 2: quotient -3, remainder -1
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    tick();

    md.md_op = 3'd5;
    md.rs_val = 32'h1234_5678;
    #2;
    check("mthi_start", md.start, 32'd0);
    tick();
    md.md_op = 3'd6;
    md.rs_val = 32'h9ABC_DEF0;
    #2;
    check("mthi_hi", md.hi, 32'h1234_5678);
    check("mthi_lo_kept", md.lo, 32'hFFFF_FFFD);
    tick();
    md.md_op = 3'd0;
    #2;
    check("mtlo_lo", md.lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", md.hi, 32'h1234_5678);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;
    tick();

    // divu by zero leaves HI/LO alone; then back-to-back accepts in cycle N+1
    run_op(3'd4, 32'd55, 32'd0, 1'b0, DIV_N, 32'd0, 32'd0, 1'b0);
    run_op(3'd4, 32'd100, 32'd7, 1'b0, DIV_N, 32'd2, 32'd14, 1'b1);
    run_op(3'd1, 32'd6, 32'd7, 1'b1, MULT_N, 32'd0, 32'd42, 1'b1);
    md.d_md = 1'b0;
    tick();

    // reset during busy cycle 3 of mult 3*4 discards the pending result
    md.md_op = 3'd1;
    md.rs_val = 32'd3;
    md.rt_val = 32'd4;
    #2;
    check("rmid_start", md.start, 32'd1);
    tick();
    md.md_op = 3'd0;
    tick();
    tick();
    #2;
    check("rmid_busy3", md.busy, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check("rmid_busy", md.busy, 32'd0);
    check("rmid_hi", md.hi, 32'd0);
    check("rmid_lo", md.lo, 32'd0);
    for (int i = 0; i < MULT_N + 1; i++) begin
      tick();
      #2;
      check("rmid_hi_after", md.hi, 32'd0);
      check("rmid_lo_after", md.lo, 32'd0);
      check("rmid_busy_after", md.busy, 32'd0);
    end

    check("protocol", proto, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
